// File: rtl/sigmul_arb.sv
// sigmul_arb: round-robin arbiter feeding one shared 11x11 significand multiplier
// through a two-stage valid/ready pipeline. Each product comes back tagged with
// the ID of the requester that issued it.

// sigmul_10: combinational product of two 11-bit significands (hidden bit included).
module sigmul_10 (
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [21:0] p
);

  // Full-width unsigned product; the caller guarantees both hidden bits are set.
  always_comb begin
    p = 22'(a) * 22'(b);
  end

endmodule

module sigmul_arb #(
  parameter int NSIG = 10,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*(NSIG+1)-1:0] req_a,
  input  logic [NREQ*(NSIG+1)-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*NSIG+1:0]        rsp_p,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  localparam int W  = NSIG + 1;
  localparam int PW = 2 * NSIG + 2;

  // Pipeline and arbitration state
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic [PW-1:0] rsp_p_q, rsp_p_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  // Combinational helpers
  logic          adv1, adv2;
  logic          found_hi, found_lo, grant_any;
  logic [IDW-1:0] winner_hi, winner_lo, winner;
  logic [W-1:0]  sel_a, sel_b;
  logic [PW-1:0] prod;
  logic          accept;

  // Shared multiplier, fed straight from the stage-1 operand registers
  sigmul_10 u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  // Round-robin pick: lowest requesting index above the pointer, else lowest at or below it
  always_comb begin
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    winner_hi = '0;
    winner_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) > ptr_q)) begin
        found_hi  = 1'b1;
        winner_hi = IDW'(i);
      end
      if (req_valid[i] && (IDW'(i) <= ptr_q)) begin
        found_lo  = 1'b1;
        winner_lo = IDW'(i);
      end
    end
    grant_any = found_hi | found_lo;
    winner    = found_hi ? winner_hi : winner_lo;
  end

  // Stage advance conditions and the one-hot ready back to the winning requester
  always_comb begin
    adv2      = ~v2_q | rsp_ready;
    adv1      = ~v1_q | adv2;
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        req_ready[i] = rst_n & grant_any & adv1;
        sel_a        = req_a[i*W +: W];
        sel_b        = req_b[i*W +: W];
      end
    end
    accept = |(req_valid & req_ready);
  end

  // Next-state for both stages and the pointer; everything holds unless its stage advances
  always_comb begin
    v1_d     = v1_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    id1_d    = id1_q;
    v2_d     = v2_q;
    rsp_p_d  = rsp_p_q;
    rsp_id_d = rsp_id_q;
    ptr_d    = ptr_q;
    if (adv2) begin
      v2_d     = v1_q;
      rsp_p_d  = prod;
      rsp_id_d = id1_q;
    end
    if (adv1) begin
      v1_d   = grant_any;
      op_a_d = sel_a;
      op_b_d = sel_b;
      id1_d  = winner;
    end
    if (accept) begin
      ptr_d = winner;
    end
  end

  // State registers; reset discards in-flight entries and gives requester 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      id1_q    <= '0;
      v2_q     <= 1'b0;
      rsp_p_q  <= '0;
      rsp_id_q <= '0;
      ptr_q    <= IDW'(NREQ - 1);
    end else begin
      v1_q     <= v1_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      id1_q    <= id1_d;
      v2_q     <= v2_d;
      rsp_p_q  <= rsp_p_d;
      rsp_id_q <= rsp_id_d;
      ptr_q    <= ptr_d;
    end
  end

  // Output drive
  always_comb begin
    rsp_valid = v2_q;
    rsp_p     = rsp_p_q;
    rsp_id    = rsp_id_q;
    busy      = v1_q | v2_q;
  end

endmodule

// File: tb/tb_sigmul_arb.sv
// Bench for sigmul_arb: per-requester operand queues drive the request side,
// a scoreboard queue holds hand-computed responses in expected order.
module tb_sigmul_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [43:0] req_a;
  logic [43:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [21:0] rsp_p;
  logic [1:0]  rsp_id;
  logic        busy;

  typedef struct packed {
    logic [10:0] a;
    logic [10:0] b;
  } op_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [21:0] p;
  } exp_t;

  op_t  pend [4][$];
  exp_t expQ [$];
  int   nChecks = 0;
  int   nFails  = 0;
  logic [3:0] acc;

  logic [3:0] rdy2 [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic       rr3  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] rdy3 [10] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
  logic       rv3  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       rr4  [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] rdy4 [12] = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                            4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0000};
  logic [3:0] rdy6 [4]  = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

  sigmul_arb #(.NSIG(10), .NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // One comparison: counts it, reports a failure with actual and required values
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Queue one operand pair on a requester
  task automatic applyStimulus(input int id, input logic [10:0] a, input logic [10:0] b);
    pend[id].push_back('{a: a, b: b});
  endtask

  // Queue one hand-computed response in the order it must emerge
  task automatic expectResponse(input logic [1:0] id, input logic [21:0] p);
    expQ.push_back('{id: id, p: p});
  endtask

  // Resynchronise the stimulus thread to just after a rising edge
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Wait for the scoreboard to empty and the pipeline to go idle, within a cycle budget
  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (expQ.size() != 0 || busy) begin
      nFails++;
      $display("[TB] FAIL drain_timeout: %0d responses still pending, busy %b, required 0 and 0", expQ.size(), busy);
    end
    sync();
  endtask

  // Requester model: hold the head operand valid until it is accepted, then present the next
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        if (pend[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_a[i*11 +: 11] = pend[i][0].a;
          req_b[i*11 +: 11] = pend[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: whenever a response is presented it must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_rsp: got id %0d p %h, required no response", rsp_id, rsp_p);
      end else begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(expQ[0].id));
        checkOutput("rsp_p", 32'(rsp_p), 32'(expQ[0].p));
        if (rsp_ready) void'(expQ.pop_front());
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    #3;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_p", 32'(rsp_p), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    #9;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    $display("[TB] test 1: single request from requester 2");
    applyStimulus(2, 11'h400, 11'h400);
    expectResponse(2'd2, 22'h100000);
    sync();
    @(negedge clk);
    checkOutput("t1_req_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    checkOutput("t1_rsp_valid_n1", 32'(rsp_valid), 32'd0);
    checkOutput("t1_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("t1_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    checkOutput("t1_rsp_valid_n3", 32'(rsp_valid), 32'd0);
    checkOutput("t1_busy_n3", 32'(busy), 32'd0);
    sync();

    $display("[TB] test 2: all requesters continuously valid");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 11'h7FF, 11'h7FF); applyStimulus(0, 11'h600, 11'h600);
    applyStimulus(1, 11'h600, 11'h400); applyStimulus(1, 11'h400, 11'h7FF);
    applyStimulus(2, 11'h400, 11'h400); applyStimulus(2, 11'h7FF, 11'h7FF);
    applyStimulus(3, 11'h7FF, 11'h400); applyStimulus(3, 11'h600, 11'h400);
    expectResponse(2'd0, 22'h3FF001);
    expectResponse(2'd1, 22'h180000);
    expectResponse(2'd2, 22'h100000);
    expectResponse(2'd3, 22'h1FFC00);
    expectResponse(2'd0, 22'h240000);
    expectResponse(2'd1, 22'h1FFC00);
    expectResponse(2'd2, 22'h3FF001);
    expectResponse(2'd3, 22'h180000);
    sync();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_req_ready_c%0d", c), 32'(req_ready), 32'(rdy2[c]));
      sync();
    end
    waitDrain(20);

    $display("[TB] test 3: backpressure");
    applyStimulus(0, 11'h7FF, 11'h7FF);
    applyStimulus(1, 11'h600, 11'h400);
    applyStimulus(2, 11'h400, 11'h400);
    expectResponse(2'd0, 22'h3FF001);
    expectResponse(2'd1, 22'h180000);
    expectResponse(2'd2, 22'h100000);
    sync();
    for (int c = 0; c < 10; c++) begin
      rsp_ready = rr3[c];
      @(negedge clk);
      checkOutput($sformatf("t3_req_ready_c%0d", c), 32'(req_ready), 32'(rdy3[c]));
      checkOutput($sformatf("t3_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(rv3[c]));
      sync();
    end
    waitDrain(20);

    $display("[TB] test 4: fairness between requesters 1 and 3 with a stall");
    applyStimulus(1, 11'h400, 11'h400); applyStimulus(1, 11'h7FF, 11'h7FF);
    applyStimulus(1, 11'h600, 11'h400); applyStimulus(1, 11'h600, 11'h600);
    applyStimulus(3, 11'h7FF, 11'h400); applyStimulus(3, 11'h400, 11'h600);
    applyStimulus(3, 11'h400, 11'h7FF); applyStimulus(3, 11'h7FF, 11'h7FF);
    expectResponse(2'd3, 22'h1FFC00);
    expectResponse(2'd1, 22'h100000);
    expectResponse(2'd3, 22'h180000);
    expectResponse(2'd1, 22'h3FF001);
    expectResponse(2'd3, 22'h1FFC00);
    expectResponse(2'd1, 22'h180000);
    expectResponse(2'd3, 22'h3FF001);
    expectResponse(2'd1, 22'h240000);
    sync();
    for (int c = 0; c < 12; c++) begin
      rsp_ready = rr4[c];
      @(negedge clk);
      checkOutput($sformatf("t4_req_ready_c%0d", c), 32'(req_ready), 32'(rdy4[c]));
      sync();
    end
    waitDrain(20);

    $display("[TB] test 6: idle period keeps the pointer");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_idle_busy_c%0d", c), 32'(busy), 32'd0);
      checkOutput($sformatf("t6_idle_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd0);
    end
    sync();
    applyStimulus(0, 11'h7FF, 11'h7FF);
    applyStimulus(1, 11'h400, 11'h400);
    applyStimulus(2, 11'h600, 11'h400);
    applyStimulus(3, 11'h600, 11'h600);
    expectResponse(2'd2, 22'h180000);
    expectResponse(2'd3, 22'h240000);
    expectResponse(2'd0, 22'h3FF001);
    expectResponse(2'd1, 22'h100000);
    sync();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_req_ready_c%0d", c), 32'(req_ready), 32'(rdy6[c]));
      sync();
    end
    waitDrain(20);

    $display("[TB] test 5: reset with both stages full");
    rsp_ready = 1'b0;
    applyStimulus(2, 11'h7FF, 11'h400);
    applyStimulus(3, 11'h400, 11'h400);
    expectResponse(2'd2, 22'h1FFC00);
    expectResponse(2'd3, 22'h100000);
    sync();
    @(negedge clk);
    checkOutput("t5_req_ready_c0", 32'(req_ready), 32'b0100);
    sync();
    @(negedge clk);
    checkOutput("t5_req_ready_c1", 32'(req_ready), 32'b1000);
    sync();
    checkOutput("t5_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_req_ready", 32'(req_ready), 32'd0);
    expQ.delete();
    for (int i = 0; i < 4; i++) pend[i].delete();
    req_valid = '0;
    sync();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(0, 11'h400, 11'h400);
    applyStimulus(3, 11'h7FF, 11'h7FF);
    expectResponse(2'd0, 22'h100000);
    expectResponse(2'd3, 22'h3FF001);
    sync();
    @(negedge clk);
    checkOutput("t5_post_req_ready_c0", 32'(req_ready), 32'b0001);
    sync();
    @(negedge clk);
    checkOutput("t5_post_req_ready_c1", 32'(req_ready), 32'b1000);
    sync();
    waitDrain(20);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_tail_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
